// File: rtl/fs_accel_pkg.sv
// Shared constants for the PU sequencer: FSM state encoding, shift directions
// and the weight-register one-hot helper.
package fs_accel_pkg;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WLOAD   = 3'd1;
   localparam logic [2:0] FILL    = 3'd2;
   localparam logic [2:0] COMPUTE = 3'd3;
   localparam logic [2:0] CAPTURE = 3'd4;
   localparam logic [2:0] SHIFT   = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   localparam logic [1:0] NON   = 2'b00;
   localparam logic [1:0] LEFT  = 2'b01;
   localparam logic [1:0] RIGHT = 2'b10;
   localparam logic [1:0] DOWN  = 2'b11;

   localparam int          OUT_W      = 96;
   localparam logic [3:0]  LAST_WBEAT = 4'd8;

   function automatic logic [8:0] wreg_onehot(input logic [3:0] k);
      return 9'(1) << k;
   endfunction

endpackage

// File: rtl/fs_accel_out_buf.sv
// Single-entry valid/ready result holding register; data only changes on load,
// so it stays stable while the consumer stalls.
module fs_accel_out_buf
   import fs_accel_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [OUT_W-1:0] din,
   input  logic             rdy,
   output logic             vld,
   output logic [OUT_W-1:0] dout,
   output logic             can_load
);

   logic             vld_q, vld_d;
   logic [OUT_W-1:0] data_q, data_d;

   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (load) begin
         vld_d  = 1'b1;
         data_d = din;
      end else if (vld_q && rdy) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q  <= vld_d;
         data_q <= data_d;
      end
   end

   assign vld      = vld_q;
   assign dout     = data_q;
   assign can_load = !vld_q || rdy;

endmodule

// File: rtl/fs_accel_pu_seq.sv
// Sequencer for the 3-PU accelerator: weight load, window fill/shift, compute,
// result capture. FS_ACCEL_SEQ_PERF_EN adds the seq_stall_cnt stall counter.
module fs_accel_pu_seq
   import fs_accel_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seq_start,
   input  logic             seq_is_conv_layer,
   input  logic             seq_keep_weights,
   input  logic [CNT_W-1:0] seq_out_w,
   input  logic [CNT_W-1:0] seq_out_h,
   input  logic             seq_wdi_vld,
   output logic             seq_wdi_rdy,
   input  logic             seq_idi_vld,
   output logic             seq_idi_rdy,
   output logic [8:0]       wreg_enb,
   output logic [2:0]       ireg_enb,
   output logic [2:0]       pu_enb,
   output logic [1:0]       conv_dir,
   output logic             is_conv_layer,
   input  logic             pu_rdy,
   input  logic [31:0]      pu_odo_0,
   input  logic [31:0]      pu_odo_1,
   input  logic [31:0]      pu_odo_2,
   output logic [95:0]      out_data,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic             busy,
   output logic             done
`ifdef FS_ACCEL_SEQ_PERF_EN
   ,output logic [31:0]     seq_stall_cnt
`endif
);

   logic [2:0]       state_q, state_d;
   logic [3:0]       beat_q, beat_d;
   logic [CNT_W-1:0] w_q, w_d, h_q, h_d, r_q, r_d, c_q, c_d;
   logic             conv_q, conv_d, done_q, done_d;

   logic [8:0]       wreg_c;
   logic [2:0]       ireg_c, pu_c;
   logic [1:0]       dir_c;
   logic             wrdy_c, irdy_c, capture, last_col, last_win;
   logic             buf_vld, can_load;
   logic [OUT_W-1:0] buf_data;

   assign last_col = (c_q == w_q - CNT_W'(1));
   assign last_win = last_col && (r_q == h_q - CNT_W'(1));

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      w_d     = w_q;
      h_d     = h_q;
      r_d     = r_q;
      c_d     = c_q;
      conv_d  = conv_q;
      done_d  = 1'b0;
      wreg_c  = '0;
      ireg_c  = '0;
      pu_c    = '0;
      dir_c   = NON;
      wrdy_c  = 1'b0;
      irdy_c  = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: if (seq_start) begin
            conv_d = seq_is_conv_layer;
            w_d    = seq_out_w;
            h_d    = seq_out_h;
            r_d    = '0;
            c_d    = '0;
            beat_d = '0;
            if (seq_out_w == '0 || seq_out_h == '0) state_d = DONE;
            else if (seq_keep_weights)              state_d = FILL;
            else                                    state_d = WLOAD;
         end
         WLOAD: begin
            wrdy_c = 1'b1;
            if (seq_wdi_vld) begin
               wreg_c = wreg_onehot(beat_q);
               beat_d = beat_q + 4'd1;
               if (beat_q == LAST_WBEAT) state_d = FILL;
            end
         end
         FILL: begin
            irdy_c = 1'b1;
            if (seq_idi_vld) begin
               ireg_c  = 3'b111;
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            pu_c = 3'b111;
            if (pu_rdy) state_d = CAPTURE;
         end
         CAPTURE: if (can_load) begin
            capture = 1'b1;
            if (last_win)    state_d = DONE;
            else if (conv_q) state_d = SHIFT;
            else begin
               // Non-conv windows advance here; conv windows advance on the shift.
               state_d = FILL;
               if (last_col) begin
                  c_d = '0;
                  r_d = r_q + CNT_W'(1);
               end else begin
                  c_d = c_q + CNT_W'(1);
               end
            end
         end
         SHIFT: begin
            irdy_c = 1'b1;
            if (seq_idi_vld) begin
               ireg_c  = 3'b111;
               state_d = COMPUTE;
               if (last_col) begin
                  dir_c = DOWN;
                  c_d   = '0;
                  r_d   = r_q + CNT_W'(1);
               end else begin
                  dir_c = r_q[0] ? LEFT : RIGHT;
                  c_d   = c_q + CNT_W'(1);
               end
            end
         end
         DONE: if (!buf_vld) begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         beat_q  <= '0;
         w_q     <= '0;
         h_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         conv_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         w_q     <= w_d;
         h_q     <= h_d;
         r_q     <= r_d;
         c_q     <= c_d;
         conv_q  <= conv_d;
         done_q  <= done_d;
      end
   end

   fs_accel_out_buf u_out_buf (
      .clk      (clk),
      .reset    (reset),
      .load     (capture),
      .din      ({pu_odo_2, pu_odo_1, pu_odo_0}),
      .rdy      (out_rdy),
      .vld      (buf_vld),
      .dout     (buf_data),
      .can_load (can_load)
   );

   // Reset masks every output combinationally so nothing leaks during the reset cycle.
   assign seq_wdi_rdy   = wrdy_c & ~reset;
   assign seq_idi_rdy   = irdy_c & ~reset;
   assign wreg_enb      = reset ? '0 : wreg_c;
   assign ireg_enb      = reset ? '0 : ireg_c;
   assign pu_enb        = reset ? '0 : pu_c;
   assign conv_dir      = reset ? NON : dir_c;
   assign is_conv_layer = conv_q & ~reset;
   assign out_data      = reset ? '0 : buf_data;
   assign out_vld       = buf_vld & ~reset;
   assign busy          = (state_q != IDLE) & ~reset;
   assign done          = done_q & ~reset;

`ifdef FS_ACCEL_SEQ_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic        stall_ev;

   always_comb begin
      stall_ev = ((state_q == CAPTURE) && !can_load) ||
                 (((state_q == FILL) || (state_q == SHIFT)) && !seq_idi_vld);
      stall_d  = stall_q;
      if ((state_q == IDLE) && seq_start)       stall_d = '0;
      else if (stall_ev && (stall_q != '1))     stall_d = stall_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) stall_q <= '0;
      else       stall_q <= stall_d;
   end

   assign seq_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fs_accel_pu_seq.sv
// Bench for fs_accel_pu_seq: window-level reference model, reactive PU model,
// per-cycle handshake monitor, directed scenarios plus randomized runs.
module tb_fs_accel_pu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        seq_start, seq_is_conv_layer, seq_keep_weights;
   logic [7:0]  seq_out_w, seq_out_h;
   logic        seq_wdi_vld, seq_wdi_rdy, seq_idi_vld, seq_idi_rdy;
   logic [8:0]  wreg_enb;
   logic [2:0]  ireg_enb, pu_enb;
   logic [1:0]  conv_dir;
   logic        is_conv_layer, pu_rdy;
   logic [31:0] pu_odo_0, pu_odo_1, pu_odo_2;
   logic [95:0] out_data;
   logic        out_vld, out_rdy, busy, done;
`ifdef FS_ACCEL_SEQ_PERF_EN
   logic [31:0] seq_stall_cnt;
`endif

   fs_accel_pu_seq #(.CNT_W(8)) dut (
      .clk(clk), .reset(reset), .seq_start(seq_start),
      .seq_is_conv_layer(seq_is_conv_layer), .seq_keep_weights(seq_keep_weights),
      .seq_out_w(seq_out_w), .seq_out_h(seq_out_h),
      .seq_wdi_vld(seq_wdi_vld), .seq_wdi_rdy(seq_wdi_rdy),
      .seq_idi_vld(seq_idi_vld), .seq_idi_rdy(seq_idi_rdy),
      .wreg_enb(wreg_enb), .ireg_enb(ireg_enb), .pu_enb(pu_enb), .conv_dir(conv_dir),
      .is_conv_layer(is_conv_layer), .pu_rdy(pu_rdy),
      .pu_odo_0(pu_odo_0), .pu_odo_1(pu_odo_1), .pu_odo_2(pu_odo_2),
      .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
      .busy(busy), .done(done)
`ifdef FS_ACCEL_SEQ_PERF_EN
      , .seq_stall_cnt(seq_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   int vld_pct = 100, rdy_pct = 100, pu_lat = 2;
   bit hold_idi = 0, hold_rdy = 0;

   logic [1:0]  exp_dir[$];
   logic [95:0] exp_q[$];
   int wcnt, icnt, ocnt, exp_wbeats, cur_n, t_start;
   bit cur_conv;

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Expected shift direction per window, straight from the serpentine walk rules.
   function automatic void build_dirs(input bit conv, input int w, input int h);
      exp_dir.delete();
      for (int k = 0; k < w * h; k++) begin
         if (k == 0 || !conv) exp_dir.push_back(2'b00);
         else begin
            int pr = (k - 1) / w;
            int pc = (k - 1) % w;
            if (pc == w - 1)     exp_dir.push_back(2'b11);
            else if (pr % 2 == 1) exp_dir.push_back(2'b01);
            else                  exp_dir.push_back(2'b10);
         end
      end
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Random valid/ready sources.
   initial begin
      seq_wdi_vld = 0; seq_idi_vld = 0; out_rdy = 0;
      forever begin
         @(posedge clk); #1;
         seq_wdi_vld = ($urandom_range(0, 99) < vld_pct);
         seq_idi_vld = !hold_idi && ($urandom_range(0, 99) < vld_pct);
         out_rdy     = !hold_rdy && ($urandom_range(0, 99) < rdy_pct);
      end
   end

   // PU model: fresh random result per window, ready after pu_lat enabled cycles.
   initial begin
      int cnt = 0;
      logic nrdy;
      logic [95:0] ndata;
      pu_rdy = 0; {pu_odo_2, pu_odo_1, pu_odo_0} = '0;
      forever begin
         @(negedge clk);
         nrdy  = pu_rdy;
         ndata = {pu_odo_2, pu_odo_1, pu_odo_0};
         if (reset) begin
            cnt = 0; nrdy = 0;
         end else if (ireg_enb == 3'b111) begin
            cnt = 0; nrdy = 0;
            ndata = {$urandom, $urandom, $urandom};
            exp_q.push_back(ndata);
         end else if (pu_enb == 3'b111) begin
            cnt++;
            if (cnt >= pu_lat) nrdy = 1;
         end
         @(posedge clk); #1;
         pu_rdy = nrdy;
         {pu_odo_2, pu_odo_1, pu_odo_0} = ndata;
      end
   end

   // Per-cycle monitor.
   initial begin
      bit          prev_hold = 0, prev_done = 0;
      logic [95:0] prev_data = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_hold = 0; prev_done = 0;
         end else begin
            if ((seq_wdi_rdy && seq_wdi_vld) || wreg_enb != 0) begin
               chk("wreg_onehot", 96'(wreg_enb), (wcnt < 9) ? 96'(9'(1) << wcnt) : 96'(0));
               chk("wreg_hs", 96'(seq_wdi_rdy && seq_wdi_vld), 96'(1));
               wcnt++;
            end
            if ((seq_idi_rdy && seq_idi_vld) || ireg_enb != 0) begin
               chk("ireg_all", 96'(ireg_enb), 96'(3'b111));
               chk("ireg_hs", 96'(seq_idi_rdy && seq_idi_vld), 96'(1));
               if (icnt < exp_dir.size()) chk("conv_dir", 96'(conv_dir), 96'(exp_dir[icnt]));
               else chk("extra_window", 96'(icnt), 96'(exp_dir.size()));
               icnt++;
            end else begin
               chk("dir_idle", 96'(conv_dir), 96'(0));
            end
            if (prev_hold && out_vld) chk("out_stable", out_data, prev_data);
            if (out_vld && out_rdy) begin
               if (exp_q.size() > 0) chk("out_data", out_data, exp_q.pop_front());
               else chk("out_extra", 96'(ocnt), 96'(cur_n));
               ocnt++;
            end
            if (done) begin
               chk("done_busy", 96'(busy), 96'(0));
               chk("done_pulse", 96'(prev_done), 96'(0));
            end
            prev_hold = out_vld && !out_rdy;
            prev_data = out_data;
            prev_done = done;
         end
      end
   end

   task automatic check_reset_outs(input string name);
      chk(name, 96'({seq_wdi_rdy, seq_idi_rdy, wreg_enb, ireg_enb, pu_enb, conv_dir,
                     is_conv_layer, |out_data, out_vld, busy, done}), 96'(0));
   endtask

   task automatic start_run(input bit conv, input bit keep, input int w, input int h, input int lat);
      build_dirs(conv, w, h);
      exp_q.delete();
      wcnt = 0; icnt = 0; ocnt = 0;
      cur_n = w * h;
      cur_conv = conv;
      exp_wbeats = (cur_n == 0 || keep) ? 0 : 9;
      pu_lat = lat;
      @(posedge clk); #1;
      seq_is_conv_layer = conv; seq_keep_weights = keep;
      seq_out_w = 8'(w); seq_out_h = 8'(h);
      seq_start = 1;
      t_start = cyc;
      @(posedge clk); #1;
      seq_start = 0;
      // Scramble the config inputs: the DUT must have latched them.
      seq_out_w = 8'($urandom); seq_out_h = 8'($urandom);
      seq_is_conv_layer = ~conv; seq_keep_weights = $urandom_range(0, 1);
      @(negedge clk);
      chk("busy_after_start", 96'(busy), 96'(1));
      chk("is_conv_latched", 96'(is_conv_layer), 96'(conv));
   endtask

   task automatic wait_done(input int budget);
      bit got = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin got = 1; break; end
      end
      chk("done_seen", 96'(got), 96'(1));
      if (got) begin
         if (cur_n == 0) chk("done_latency", 96'(cyc - t_start), 96'(2));
         chk("wreg_beats", 96'(wcnt), 96'(exp_wbeats));
         chk("windows", 96'(icnt), 96'(cur_n));
         chk("results", 96'(ocnt), 96'(cur_n));
         chk("pending", 96'(exp_q.size()), 96'(0));
      end
   endtask

   initial begin
      int got_ev;
      int base;
      reset = 1; seq_start = 0; seq_is_conv_layer = 0; seq_keep_weights = 0;
      seq_out_w = 0; seq_out_h = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outs("reset_state");
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      check_reset_outs("idle_after_reset");

      // Pin the direction model with hand-derived sequences.
      build_dirs(1, 3, 2);
      chk("model_conv_3x2", 96'({exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_dir[4], exp_dir[5]}),
          96'({2'b00, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01}));
      build_dirs(0, 4, 1);
      chk("model_nonconv_4x1", 96'({exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3]}), 96'(0));
      build_dirs(1, 2, 3);
      chk("model_conv_2x3", 96'({exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_dir[4], exp_dir[5]}),
          96'({2'b00, 2'b10, 2'b11, 2'b01, 2'b11, 2'b10}));

      // Conv 3x2 with weight load, PU ready two cycles after enable.
      vld_pct = 100; rdy_pct = 100;
      start_run(1, 0, 3, 2, 2);
      wait_done(500);

      // Non-conv 4x1, weights kept.
      start_run(0, 1, 4, 1, 2);
      wait_done(500);

      // Consumer stalls for 10 cycles on the second result.
      start_run(1, 1, 3, 2, 2);
      got_ev = 0;
      for (int i = 0; i < 300 && ocnt < 1; i++) @(negedge clk);
      hold_rdy = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_vld) begin got_ev = 1; break; end
      end
      chk("second_result_seen", 96'(got_ev), 96'(1));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         seq_start = (i == 3);
      end
      seq_start = 0;
      chk("hold_no_drain", 96'(ocnt), 96'(1));
      chk("hold_vld", 96'(out_vld), 96'(1));
      hold_rdy = 0;
      wait_done(500);

      // Zero-width layer.
      start_run(1, 0, 0, 3, 2);
      wait_done(10);

      // Reset during COMPUTE, then a normal run.
      start_run(1, 0, 3, 3, 3);
      got_ev = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (pu_enb == 3'b111) begin got_ev = 1; break; end
      end
      chk("compute_reached", 96'(got_ev), 96'(1));
      @(posedge clk); #1 reset = 1;
      @(negedge clk);
      check_reset_outs("reset_mid_run");
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      check_reset_outs("idle_after_mid_reset");
      start_run(1, 0, 2, 2, 2);
      wait_done(500);

      // Input withheld for 5 cycles in SHIFT.
      start_run(1, 1, 2, 1, 2);
      for (int i = 0; i < 300 && icnt < 1; i++) @(negedge clk);
      hold_idi = 1;
      got_ev = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_vld) begin got_ev = 1; break; end
      end
      chk("shift_reached", 96'(got_ev), 96'(1));
      base = 0;
`ifdef FS_ACCEL_SEQ_PERF_EN
      base = int'(seq_stall_cnt);
`endif
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("shift_wait_ireg", 96'(ireg_enb), 96'(0));
      end
      hold_idi = 0;
      @(negedge clk);
      chk("shift_release_ireg", 96'(ireg_enb), 96'(3'b111));
`ifdef FS_ACCEL_SEQ_PERF_EN
      chk("stall_cnt", 96'(seq_stall_cnt), 96'(base + 5));
`endif
      wait_done(500);

      // Randomized layers with random backpressure.
      vld_pct = 70; rdy_pct = 60;
      for (int t = 0; t < 10; t++) begin
         int rw = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
         int rh = int'($urandom_range(1, 3));
         start_run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rw, rh,
                   int'($urandom_range(1, 4)));
         wait_done(3000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fs_accel_pu_seq.md
FS_ACCEL_PU_SEQ -- requirements
Module: fs_accel_pu_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 8, setting the width of the output-window row/column counters.
REQ-002 SHALL have the following ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- seq_start  in  1  one-cycle start pulse, sampled in IDLE only.
- seq_is_conv_layer  in  1  layer type, latched at start.
- seq_keep_weights  in  1  skip weight load, latched at start.
- seq_out_w  in  CNT_W  output columns per row, latched at start.
- seq_out_h  in  CNT_W  output rows, latched at start.
- seq_wdi_vld  in  1  weight beat valid.
- seq_wdi_rdy  out  1  weight beat accepted.
- seq_idi_vld  in  1  input beat valid.
- seq_idi_rdy  out  1  input beat accepted.
- wreg_enb  out  9  one-hot weight-register enable; bit 3*r+c drives wreg r_c.
- ireg_enb  out  3  input-register enables.
- pu_enb  out  3  processing-unit enables.
- conv_dir  out  2  00 NON, 01 LEFT, 10 RIGHT, 11 DOWN.
- is_conv_layer  out  1  latched layer type.
- pu_rdy  in  1  OR of the three PU ready flags.
- pu_odo_0, pu_odo_1, pu_odo_2  in  32 each  PU results.
- out_data  out  96  {odo_2, odo_1, odo_0}.
- out_vld  out  1  result valid.
- out_rdy  in  1  result accepted.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 SHALL implement the FSM states IDLE, WLOAD, FILL, COMPUTE, CAPTURE, SHIFT and DONE.
REQ-004 SHALL leave IDLE on seq_start: to DONE if seq_out_w==0 or seq_out_h==0; to FILL if seq_keep_weights=1; otherwise to WLOAD.
REQ-005 SHALL, in WLOAD, assert seq_wdi_rdy and accept exactly 9 beats, where beat k (k=0..8) asserts wreg_enb bit k only in its handshake cycle; the FSM moves to FILL after beat 8.
REQ-006 SHALL, in FILL, assert seq_idi_rdy and drive conv_dir=00; on the handshake cycle ireg_enb=111 and the FSM moves to COMPUTE.
REQ-007 SHALL, in COMPUTE, hold pu_enb=111 until pu_rdy is sampled high, then move to CAPTURE.
REQ-008 SHALL, in CAPTURE, load out_data from pu_odo_* and set out_vld when the output buffer is empty or is draining that same cycle (out_vld & out_rdy); otherwise it SHALL stay in CAPTURE.
REQ-009 SHALL, after the capture of window (r,c), branch as follows: to DONE if it was the last window; in conv mode to SHIFT; in non-conv mode to FILL.
REQ-010 SHALL, in SHIFT, assert seq_idi_rdy; on the handshake cycle ireg_enb=111, then go to COMPUTE. conv_dir SHALL be:
- RIGHT when c<w-1 and r is even; c increments.
- LEFT when c<w-1 and r is odd; c increments.
- DOWN when c==w-1; r increments and c resets to 0.
REQ-011 SHALL count windows in row-major order in non-conv mode; the total window count is seq_out_w*seq_out_h in both modes.
REQ-012 SHALL drive conv_dir=00 in every cycle where ireg_enb==000.
REQ-013 SHALL drive seq_wdi_rdy and seq_idi_rdy combinationally from state only, independent of their valid inputs.
REQ-014 SHALL, in DONE, wait until out_vld==0, then pulse done for one cycle and return to IDLE.
REQ-015 SHALL clear out_vld on out_rdy when no capture occurs in that cycle; out_data SHALL stay stable while out_vld & !out_rdy.
REQ-016 SHALL ignore seq_start outside IDLE.

Reset
REQ-017 SHALL, while reset is high, force the following, regardless of state (including mid-operation):
- FSM to IDLE.
- Counters to 0.
- wreg_enb, ireg_enb, pu_enb, conv_dir, is_conv_layer, out_data, out_vld, busy, done and both rdy outputs to 0.

Configuration
REQ-018 SHALL, with FS_ACCEL_SEQ_PERF_EN defined, add the following output:
- seq_stall_cnt  out  32  cycles spent in CAPTURE blocked or in FILL/SHIFT without seq_idi_vld.
- It SHALL be cleared by reset and by seq_start, and SHALL saturate at all-ones.
REQ-019 SHALL, without FS_ACCEL_SEQ_PERF_EN, omit that port and its counter entirely.

Structure
REQ-020 SHALL take the state encoding and the conv_dir constants NON/LEFT/RIGHT/DOWN from the shared package fs_accel_pkg.
REQ-021 SHALL implement the output buffer as the sub-module fs_accel_out_buf (96-bit, single entry, valid/ready).

Verification
REQ-022 SHALL cover each of the following directed scenarios:
- Start, w=3, h=2, conv, keep_weights=0, pu_rdy 2 cycles after pu_enb -> 9 one-hot wreg_enb pulses, then conv_dir NON, R, R, D, L, L across the window transitions, 6 out_vld beats, done.
- Non-conv, w=4, h=1 -> 4 FILL beats all with conv_dir=00, 4 results, no SHIFT state entered.
- out_rdy held low for 10 cycles at the 2nd result -> FSM holds in CAPTURE, out_data stable, no result lost or duplicated.
- w=0 -> done asserted 2 cycles after start; no enable ever asserted.
- Reset raised during COMPUTE -> next cycle all outputs 0 and state IDLE; a following start runs normally.
- seq_idi_vld withheld 5 cycles in SHIFT with PERF_EN -> ireg_enb stays 0 and seq_stall_cnt increments by 5.
